// File: rtl/conv_mem_pkg.sv
// conv_mem_pkg: shared definitions for the convolution engine memory-port
// arbiter.
//   - Requester index constants (filter, image, result) and requester count.
//   - Arbiter FSM state encoding and the state_t enum built from it.
//   - onehot_to_idx: converts a one-hot grant vector to a requester index.
package conv_mem_pkg;

   localparam int NUM_REQ = 3;

   localparam logic [1:0] REQ_FILTER = 2'd0;
   localparam logic [1:0] REQ_IMG    = 2'd1;
   localparam logic [1:0] REQ_RES    = 2'd2;

   localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
   localparam logic [1:0] ST_XFER_ENC  = 2'd1;
   localparam logic [1:0] ST_DRAIN_ENC = 2'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = ST_IDLE_ENC,
      ST_XFER  = ST_XFER_ENC,
      ST_DRAIN = ST_DRAIN_ENC
   } state_t;

   // The input is assumed one-hot; an all-zero vector maps to REQ_FILTER.
   function automatic logic [1:0] onehot_to_idx(input logic [NUM_REQ-1:0] oh);
      if (oh[REQ_RES])
         return REQ_RES;
      else if (oh[REQ_IMG])
         return REQ_IMG;
      else
         return REQ_FILTER;
   endfunction

endpackage

// File: rtl/arb_pick.sv
// arb_pick: purely combinational winner selection for the memory-port
// arbiter.
// Ports:
//   req    [NUM_REQ-1:0]  active requests
//   ptr    [1:0]          round-robin search start index
//   winner [NUM_REQ-1:0]  one-hot winner, all-zero when req is zero
// Build option: MEM_ARB_ROUND_ROBIN_EN selects round-robin starting at ptr;
// otherwise fixed priority result > filter > image and ptr is ignored.
module arb_pick
   import conv_mem_pkg::*;
(
   input  logic [NUM_REQ-1:0] req,
   input  logic [1:0]         ptr,
   output logic [NUM_REQ-1:0] winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
   always_comb begin
      winner = '0;
      // Visit ptr, ptr+1, ptr+2 (mod 3); the first active request wins.
      for (int k = 0; k < NUM_REQ; k++) begin
         int i;
         i = (int'(ptr) + k) % NUM_REQ;
         if ((winner == '0) && req[i])
            winner[i] = 1'b1;
      end
   end
`else
   logic ptr_unused;
   assign ptr_unused = ^ptr;

   always_comb begin
      winner = '0;
      if (req[REQ_RES])
         winner[REQ_RES] = 1'b1;
      else if (req[REQ_FILTER])
         winner[REQ_FILTER] = 1'b1;
      else if (req[REQ_IMG])
         winner[REQ_IMG] = 1'b1;
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares the convolution engine's single memory port among
// the filter loader (0, read), image-slice loader (1, read) and result
// write-back (2, write). Latches one burst descriptor per grant and drives
// sequential addresses for the whole burst, then pulses done.
// Ports:
//   clk, rst          rising-edge clock, asynchronous active-high reset
//   req               per-requester request
//   base_addr         packed start addresses, requester i at [i*ADDR_W +: ADDR_W]
//   burst_len         packed burst lengths, same packing (0 behaves as 1)
//   wr_data           write word from the result requester
//   gnt               one-hot grant, held for XFER and DRAIN
//   done              one-cycle completion pulse (DRAIN)
//   mem_en, mem_we    access strobe and write enable
//   mem_adr           access address (wraps modulo 2^ADDR_W)
//   mem_wdata         combinational copy of wr_data
//   rd_valid          read word on memory output is valid (readers only)
//   word_idx          index of word being written (XFER) or returned (rd_valid)
//   fsm_state         current arbiter state, for observation
// Handshake: req is sampled only in IDLE; the descriptor is captured at the
// grant edge and later changes or req drops are ignored until the burst ends.
// A req still high in the IDLE after DRAIN counts as a new request.
// Build option: MEM_ARB_ROUND_ROBIN_EN (see arb_pick).
module mem_port_arbiter
   import conv_mem_pkg::*;
#(
   parameter int ADDR_W = 12,
   parameter int DATA_W = 32,
   parameter int LEN_W  = 5
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req,
   input  logic [NUM_REQ*ADDR_W-1:0] base_addr,
   input  logic [NUM_REQ*LEN_W-1:0]  burst_len,
   input  logic [DATA_W-1:0]         wr_data,
   output logic [NUM_REQ-1:0]        gnt,
   output logic [NUM_REQ-1:0]        done,
   output logic                      mem_en,
   output logic                      mem_we,
   output logic [ADDR_W-1:0]         mem_adr,
   output logic [DATA_W-1:0]         mem_wdata,
   output logic                      rd_valid,
   output logic [LEN_W-1:0]          word_idx,
   output state_t                    fsm_state
);

   state_t              state;
   logic [1:0]          ptr;
   logic [NUM_REQ-1:0]  pick;
   logic [1:0]          pick_idx;
   logic [ADDR_W-1:0]   sel_base;
   logic [LEN_W-1:0]    sel_len;
   logic [LEN_W-1:0]    eff_len;
   logic [1:0]          win_idx;
   logic [ADDR_W-1:0]   base_q;
   logic [LEN_W-1:0]    len_q;
   logic [LEN_W-1:0]    cnt;
   logic                last_word;
   logic                is_wr;

   arb_pick u_arb_pick (
      .req    (req),
      .ptr    (ptr),
      .winner (pick)
   );

   assign pick_idx  = onehot_to_idx(pick);
   assign sel_base  = base_addr[int'(pick_idx)*ADDR_W +: ADDR_W];
   assign sel_len   = burst_len[int'(pick_idx)*LEN_W +: LEN_W];
   assign eff_len   = (sel_len == '0) ? LEN_W'(1) : sel_len;
   assign last_word = (cnt == len_q - LEN_W'(1));
   assign is_wr     = (win_idx == REQ_RES);

   assign mem_wdata = wr_data;
   assign fsm_state = state;

`ifndef MEM_ARB_ROUND_ROBIN_EN
   assign ptr = 2'd0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         gnt      <= '0;
         done     <= '0;
         mem_en   <= 1'b0;
         mem_we   <= 1'b0;
         mem_adr  <= '0;
         rd_valid <= 1'b0;
         word_idx <= '0;
         win_idx  <= REQ_FILTER;
         base_q   <= '0;
         len_q    <= '0;
         cnt      <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         ptr      <= 2'd0;
`endif
      end else begin
         done <= '0;
         case (state)
            ST_IDLE: begin
               rd_valid <= 1'b0;
               word_idx <= '0;
               if (req != '0) begin
                  win_idx <= pick_idx;
                  base_q  <= sel_base;
                  len_q   <= eff_len;
                  cnt     <= '0;
                  gnt     <= pick;
                  mem_en  <= 1'b1;
                  mem_we  <= (pick_idx == REQ_RES);
                  mem_adr <= sel_base;
                  state   <= ST_XFER;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  ptr     <= (pick_idx == 2'(NUM_REQ - 1)) ? 2'd0 : pick_idx + 2'd1;
`endif
               end
            end

            ST_XFER: begin
               // Read data returns one cycle after its address, so the
               // returned index is the current cnt.
               rd_valid <= !is_wr;
               if (is_wr)
                  word_idx <= last_word ? '0 : cnt + LEN_W'(1);
               else
                  word_idx <= cnt;
               if (last_word) begin
                  mem_en        <= 1'b0;
                  mem_we        <= 1'b0;
                  mem_adr       <= '0;
                  done[win_idx] <= 1'b1;
                  state         <= ST_DRAIN;
               end else begin
                  cnt     <= cnt + LEN_W'(1);
                  mem_adr <= base_q + ADDR_W'(cnt) + ADDR_W'(1);
               end
            end

            ST_DRAIN: begin
               gnt      <= '0;
               rd_valid <= 1'b0;
               word_idx <= '0;
               state    <= ST_IDLE;
            end

            default: begin
               gnt      <= '0;
               mem_en   <= 1'b0;
               mem_we   <= 1'b0;
               rd_valid <= 1'b0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed bench for mem_port_arbiter. Drivers push the
// expected memory accesses, read returns and done pulses into queues; a
// negedge monitor pops and compares whenever the DUT presents them.
// Honours MEM_ARB_ROUND_ROBIN_EN to choose the expected grant order.
module tb_mem_port_arbiter;
   import conv_mem_pkg::*;

   localparam logic [31:0] PAT = 32'h5A00_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  req = 3'b000;
   logic [35:0] base_addr = '0;
   logic [14:0] burst_len = '0;
   logic [31:0] wr_data;
   logic [2:0]  gnt, done;
   logic        mem_en, mem_we, rd_valid;
   logic [11:0] mem_adr;
   logic [31:0] mem_wdata;
   logic [4:0]  word_idx;
   state_t      fsm_state;

   int checks = 0;
   int errors = 0;

   // {pad11, we, gnt3, widx5, adr12, wdata32}
   logic [63:0] acc_q[$];
   // {gnt3, idx5}
   logic [7:0]  rd_q[$];
   logic [2:0]  done_q[$];

   // Clock / reset
   always #5 clk = ~clk;

   // The result requester presents the word the arbiter asks for.
   assign wr_data = PAT | {27'd0, word_idx};

   mem_port_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .base_addr (base_addr),
      .burst_len (burst_len),
      .wr_data   (wr_data),
      .gnt       (gnt),
      .done      (done),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_adr   (mem_adr),
      .mem_wdata (mem_wdata),
      .rd_valid  (rd_valid),
      .word_idx  (word_idx),
      .fsm_state (fsm_state)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   // Driver tasks
   task automatic set_desc(input int who, input logic [11:0] b, input logic [4:0] l);
      base_addr[who*12 +: 12] = b;
      burst_len[who*5 +: 5]   = l;
   endtask

   // stop > 0: burst is cut by reset during its access number 'stop-1'.
   task automatic push_burst(input int who, input logic [11:0] base, input int len, input int stop);
      int n;
      int na;
      int nr;
      logic [2:0] g;
      n  = (len == 0) ? 1 : len;
      na = (stop > 0) ? stop : n;
      nr = (stop > 0) ? stop - 1 : n;
      g  = 3'b001 << who;
      for (int k = 0; k < na; k++) begin
         logic [11:0] a;
         a = base + 12'(k);
         acc_q.push_back({11'd0, (who == 2), g, 5'(k), a, PAT + 32'(k)});
      end
      if (who != 2)
         for (int k = 0; k < nr; k++) rd_q.push_back({g, 5'(k)});
      if (stop == 0) done_q.push_back(g);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      req = 3'b000;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic wait_done(input logic [2:0] mask, input string name);
      int n;
      n = 0;
      @(negedge clk);
      while (((done & mask) == 3'b000) && (n < 60)) begin
         @(negedge clk);
         n++;
      end
      if ((done & mask) == 3'b000) begin
         checks++;
         errors++;
         $display("FAIL %s: done timeout, got done=%b required %b", name, done, mask);
      end
   endtask

   task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h required %0h", name, got, exp);
      end
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_en) begin
            logic [63:0] e;
            checks++;
            if (acc_q.size() == 0) begin
               errors++;
               $display("FAIL access: unexpected access adr=%h gnt=%b, required none", mem_adr, gnt);
            end else begin
               e = acc_q.pop_front();
               if ((mem_we !== e[52]) || (gnt !== e[51:49]) || (mem_adr !== e[43:32]) ||
                   (e[52] && ((word_idx !== e[48:44]) || (mem_wdata !== e[31:0])))) begin
                  errors++;
                  $display("FAIL access: got we=%b gnt=%b idx=%0d adr=%h wd=%h required we=%b gnt=%b idx=%0d adr=%h wd=%h",
                           mem_we, gnt, word_idx, mem_adr, mem_wdata,
                           e[52], e[51:49], e[48:44], e[43:32], e[31:0]);
               end
            end
         end
         if (rd_valid) begin
            logic [7:0] r;
            checks++;
            if (rd_q.size() == 0) begin
               errors++;
               $display("FAIL read: unexpected rd_valid gnt=%b idx=%0d, required none", gnt, word_idx);
            end else begin
               r = rd_q.pop_front();
               if ({gnt, word_idx} !== r) begin
                  errors++;
                  $display("FAIL read: got gnt=%b idx=%0d required gnt=%b idx=%0d",
                           gnt, word_idx, r[7:5], r[4:0]);
               end
            end
         end
         if (done != 3'b000) begin
            logic [2:0] d;
            checks++;
            if (done_q.size() == 0) begin
               errors++;
               $display("FAIL done: unexpected done=%b, required none", done);
            end else begin
               d = done_q.pop_front();
               if ((done !== d) || (gnt !== d) || (fsm_state !== ST_DRAIN)) begin
                  errors++;
                  $display("FAIL done: got done=%b gnt=%b state=%0d required done=%b gnt=%b state=%0d",
                           done, gnt, fsm_state, d, d, ST_DRAIN);
               end
            end
         end
      end
   end

   // Stimulus
   initial begin
      int n;
      int order[3];
      int lens[3];
      int w1, w2;

      // Reset state
      repeat (3) @(negedge clk);
      check("reset_gnt",   64'(gnt), 64'd0);
      check("reset_done",  64'(done), 64'd0);
      check("reset_en_we", 64'({mem_en, mem_we, rd_valid}), 64'd0);
      check("reset_adr",   64'(mem_adr), 64'd0);
      check("reset_idx",   64'(word_idx), 64'd0);
      check("reset_state", 64'(fsm_state), 64'(ST_IDLE));
      rst = 1'b0;

      // Single filter burst, base 0x010 len 4
      @(negedge clk);
      set_desc(0, 12'h010, 5'd4);
      push_burst(0, 12'h010, 4, 0);
      req = 3'b001;
      @(negedge clk);
      req = 3'b000;
      check("filter_first_gnt",   64'(gnt), 64'b001);
      check("filter_first_state", 64'(fsm_state), 64'(ST_XFER));
      check("filter_first_en",    64'(mem_en), 64'd1);
      n = 1;
      while ((gnt != 3'b000) && (n < 40)) begin
         @(negedge clk);
         if (gnt != 3'b000) n++;
      end
      check("filter_gnt_cycles", 64'(n), 64'd5);

      // Simultaneous req=111 from pointer 0
      do_reset();
      set_desc(0, 12'h100, 5'd2);
      set_desc(1, 12'h200, 5'd3);
      set_desc(2, 12'h300, 5'd1);
      lens = '{2, 3, 1};
`ifdef MEM_ARB_ROUND_ROBIN_EN
      order = '{0, 1, 2};
`else
      order = '{2, 0, 1};
`endif
      for (int i = 0; i < 3; i++)
         push_burst(order[i], 12'h100 * 12'(order[i] + 1), lens[order[i]], 0);
      @(negedge clk);
      req = 3'b111;
      for (int i = 0; i < 3; i++) begin
         wait_done(3'b001 << order[i], "simul_req");
         req[order[i]] = 1'b0;
      end

      // Result write with address wrap
      @(negedge clk);
      set_desc(2, 12'hFFE, 5'd4);
      push_burst(2, 12'hFFE, 4, 0);
      req = 3'b100;
      @(negedge clk);
      req = 3'b000;
      set_desc(2, 12'h777, 5'd9);
      wait_done(3'b100, "result_write");

      // burst_len 0 acts as a single word
      @(negedge clk);
      set_desc(0, 12'h055, 5'd0);
      push_burst(0, 12'h055, 0, 0);
      req = 3'b001;
      @(negedge clk);
      req = 3'b000;
      wait_done(3'b001, "len_zero");

      // Reset during cnt=2 of an 8-word image burst
      @(negedge clk);
      set_desc(1, 12'h400, 5'd8);
      push_burst(1, 12'h400, 8, 3);
      req = 3'b010;
      n = 0;
      @(negedge clk);
      req = 3'b000;
      while (!(mem_en && (mem_adr == 12'h402)) && (n < 20)) begin
         @(negedge clk);
         n++;
      end
      check("abort_reached_cnt2", 64'(mem_adr), 64'h402);
      #2 rst = 1'b1;
      #1;
      check("abort_outputs",
            64'({gnt, done, mem_en, mem_we, mem_adr, rd_valid, word_idx}), 64'd0);
      check("abort_state", 64'(fsm_state), 64'(ST_IDLE));
      @(negedge clk);
      rst = 1'b0;
      set_desc(1, 12'h400, 5'd2);
      push_burst(1, 12'h400, 2, 0);
      @(negedge clk);
      req = 3'b010;
      @(negedge clk);
      req = 3'b000;
      wait_done(3'b010, "after_abort");

      // Requester keeps req high after done while another is pending
      do_reset();
      set_desc(0, 12'h020, 5'd1);
      set_desc(2, 12'h030, 5'd1);
`ifdef MEM_ARB_ROUND_ROBIN_EN
      w1 = 0;
      w2 = 2;
`else
      w1 = 2;
      w2 = 2;
`endif
      push_burst(w1, (w1 == 2) ? 12'h030 : 12'h020, 1, 0);
      push_burst(w2, (w2 == 2) ? 12'h030 : 12'h020, 1, 0);
      @(negedge clk);
      req = 3'b101;
      wait_done(3'b001 << w1, "held_req_first");
      @(negedge clk);
      @(negedge clk);
      check("held_req_second_gnt", 64'(gnt), 64'(3'b001 << w2));
      req = 3'b000;
      wait_done(3'b001 << w2, "held_req_second");

      // Drain and report
      repeat (6) @(negedge clk);
      check("acc_q_empty",  64'(acc_q.size()), 64'd0);
      check("rd_q_empty",   64'(rd_q.size()), 64'd0);
      check("done_q_empty", 64'(done_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
